// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   Elastic register chain carrying one packed stage payload between core
//   stages. It has a valid/ready handshake on both sides, back-pressure,
//   a synchronous flush and an occupancy count.
//
//   Build option: define PIPE_SKID_EN to give each slice a one-entry skid
//   register. Every ready is then registered and capacity doubles to
//   2*STAGES. With it undefined, the ready path is combinational from
//   out_ready to in_ready and capacity is STAGES.
//
// Ports
//   clk        core clock; all state changes on the rising edge
//   rst        synchronous, active-high reset (takes priority over flush)
//   flush      clears every valid bit; an input handshake in the same cycle
//              is dropped
//   in_valid   upstream presents in_data
//   in_ready   the chain accepts a payload this cycle
//   in_data    upstream payload, DATA_W bits
//   out_valid  the chain presents out_data
//   out_ready  downstream consumes out_data this cycle
//   out_data   downstream payload, DATA_W bits
//   occupancy  number of valid entries held (slices plus skid slots)
module pipe_stage_chain #(
   parameter int DATA_W = 64,
   parameter int STAGES = 1,
   parameter int OCC_W  = $clog2(2*STAGES+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [OCC_W-1:0]  occupancy
);

   logic [STAGES-1:0]             main_v;
   logic [STAGES-1:0][DATA_W-1:0] main_d;
   logic [STAGES-1:0]             up_v;   // valid presented to slice i
   logic [STAGES-1:0][DATA_W-1:0] up_d;   // payload presented to slice i

   always_comb begin
      up_v[0] = in_valid;
      up_d[0] = in_data;
      for (int i = 1; i < STAGES; i++) begin
         up_v[i] = main_v[i-1];
         up_d[i] = main_d[i-1];
      end
   end

   assign out_valid = main_v[STAGES-1];
   assign out_data  = main_d[STAGES-1];

`ifdef PIPE_SKID_EN
   logic [STAGES-1:0]             skid_v;
   logic [STAGES-1:0][DATA_W-1:0] skid_d;
   // nxt_free[i] is the registered ready offered to slice i-1 (or upstream
   // when i = 0). The top bit is the downstream ready.
   logic [STAGES:0]               nxt_free;

   assign nxt_free = {out_ready, ~skid_v};
   assign in_ready = nxt_free[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         main_v <= '0;
         main_d <= '0;
         skid_v <= '0;
         skid_d <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (!main_v[i] || nxt_free[i+1]) begin
               // The main register frees up. The skid entry is older than
               // anything upstream, so it refills the main register first.
               if (skid_v[i]) begin
                  main_v[i] <= 1'b1;
                  main_d[i] <= skid_d[i];
                  skid_v[i] <= 1'b0;
               end else begin
                  main_v[i] <= up_v[i];
                  if (up_v[i]) main_d[i] <= up_d[i];
               end
            end else if (up_v[i] && !skid_v[i]) begin
               // The main register is stalled but ready was still high.
               // Catch the in-flight item in the skid register.
               skid_v[i] <= 1'b1;
               skid_d[i] <= up_d[i];
            end
         end
         if (flush) begin
            main_v <= '0;
            skid_v <= '0;
         end
      end
   end

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < STAGES; i++)
         occupancy = occupancy + OCC_W'(main_v[i]) + OCC_W'(skid_v[i]);
   end
`else
   // rdy[i]: slice i can load this cycle, because it is empty or its
   // successor takes its entry. The chain is resolved from the output end.
   logic [STAGES:0] rdy;

   always_comb begin
      rdy[STAGES] = out_ready;
      for (int i = STAGES-1; i >= 0; i--)
         rdy[i] = ~main_v[i] | rdy[i+1];
   end

   assign in_ready = rdy[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         main_v <= '0;
         main_d <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (rdy[i]) begin
               main_v[i] <= up_v[i];
               if (up_v[i]) main_d[i] <= up_d[i];
            end
         end
         if (flush) main_v <= '0;
      end
   end

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < STAGES; i++)
         occupancy = occupancy + OCC_W'(main_v[i]);
   end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;
   localparam int DW = 16;
   localparam int ST = 2;
   localparam int OW = $clog2(2*ST+1);
`ifdef PIPE_SKID_EN
   localparam int CAP = 2*ST;
`else
   localparam int CAP = ST;
`endif

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic [OW-1:0] occupancy;

   pipe_stage_chain #(.DATA_W(DW), .STAGES(ST)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int n_pop = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard + occupancy model, sampled mid-cycle when inputs are stable
   logic [DW-1:0] sb_q[$];
   logic [DW-1:0] exp_d;
   logic          mon_en = 1'b0;
   int            occ_m = 0;
   logic          in_hs, out_hs;
   logic          p_ov = 1'b0, p_or = 1'b0, p_fl = 1'b0;
   logic [DW-1:0] p_od = '0;

   always @(negedge clk) begin
      if (mon_en) begin
         in_hs  = in_valid && in_ready;
         out_hs = out_valid && out_ready;
         chk("occ", occupancy, occ_m);
         if (occ_m == 0) chk("ov_idle", out_valid, 0);
`ifdef PIPE_SKID_EN
         if (occ_m == CAP) chk("full_rdy", in_ready, 0);
`else
         chk("rdy", in_ready, (occ_m < CAP) || out_ready);
`endif
         if (p_ov && !p_or && !p_fl) begin
            chk("stab_v", out_valid, 1);
            chk("stab_d", out_data, p_od);
         end
         if (out_hs) begin
            if (sb_q.size() == 0) chk("sb_underflow", sb_q.size(), 1);
            else begin
               exp_d = sb_q.pop_front();
               chk("sb_data", out_data, exp_d);
               n_pop++;
            end
         end
         if (flush) begin
            sb_q.delete();
            occ_m = 0;
         end else begin
            if (in_hs) sb_q.push_back(in_data);
            occ_m = occ_m + int'(in_hs) - int'(out_hs);
         end
         p_ov = out_valid; p_or = out_ready; p_fl = flush; p_od = out_data;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nacc, pop0, j;
      bit acc;
      // reset with garbage offered
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'hDEAD; out_ready = 1'b0;
      step(); step();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("rst_ov", out_valid, 0);
      chk("rst_od", out_data, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_rdy", in_ready, 1);
      mon_en = 1'b1;

      // back-to-back stream: first output STAGES-1 edges after accept
      out_ready = 1'b1;
      for (int k = 0; k < ST + 5; k++) begin
         in_valid = (k < 4);
         in_data  = DW'(k + 1);
         @(negedge clk);
         if (k < 4) chk("st_rdy", in_ready, 1);
         step();
         j = k - (ST - 1);
         if (j >= 0 && j < 4) begin
            chk("st_ov", out_valid, 1);
            chk("st_od", out_data, j + 1);
         end else chk("st_ov0", out_valid, 0);
      end

      // stall: keep offering while downstream blocks
      out_ready = 1'b0; nacc = 0;
      for (int k = 0; k < CAP + 5; k++) begin
         in_valid = 1'b1;
         in_data  = DW'(16'hA + nacc);
         @(negedge clk);
         acc = in_ready;
         step();
         if (acc) nacc++;
      end
      chk("stall_occ", occupancy, CAP);
      chk("stall_rdy", in_ready, 0);
      chk("stall_ov", out_valid, 1);
      chk("stall_od", out_data, 16'hA);
      chk("stall_acc", nacc, CAP);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 20 && occupancy != 0; k++) step();
      chk("stall_drain", occupancy, 0);

      // flush with a coincident input: 0x33 must never appear
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'h11; step();
      in_data = 16'h22; step();
      in_data = 16'h33; flush = 1'b1; step();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_ov", out_valid, 0);
      chk("fl_occ", occupancy, 0);
      out_ready = 1'b1;
      step(); step(); step();

      // flush coinciding with an output handshake: item counts as consumed
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'h55; step();
      in_valid = 1'b0;
      for (int k = 0; k < 20 && !out_valid; k++) step();
      chk("fd_wait", out_valid, 1);
      pop0 = n_pop;
      out_ready = 1'b1; flush = 1'b1; step();
      flush = 1'b0;
      chk("fd_pop", n_pop - pop0, 1);
      chk("fd_ov", out_valid, 0);
      step(); step();
      chk("fd_nodup", n_pop - pop0, 1);

      // random traffic
      for (int k = 0; k < 10000; k++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         in_data   = DW'($urandom);
         out_ready = ($urandom_range(0, 99) < 65);
         flush     = ($urandom_range(0, 99) < 5);
         step();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 50 && occupancy != 0; k++) step();
      step();
      chk("rnd_drain", sb_q.size(), 0);
      chk("rnd_occ", occupancy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
